// File: rtl/decoder_3to8_seq_if.sv
// Handshake and output bundle for the sequenced 3-to-8 decoder.
// master drives codes in, slave is the decoder itself.
interface decoder_3to8_seq_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_code;
   logic [7:0] out;
   logic       busy;
   logic       done;

   modport master (
      output in_valid,
      output in_code,
      input  in_ready,
      input  out,
      input  busy,
      input  done
   );

   modport slave (
      input  in_valid,
      input  in_code,
      output in_ready,
      output out,
      output busy,
      output done
   );
endinterface

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 one-hot decoder: each accepted code becomes a timed one-hot
// strobe of HOLD_CYCLES cycles followed by a GAP_CYCLES all-zero gap.
//
// state | meaning
// IDLE  | ready for a code, out all zero
// HOLD  | one-hot bit asserted, counting down the hold time
// GAP   | out forced to zero, counting down the gap before the next accept
module decoder_3to8_seq #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   decoder_3to8_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

   state_t     state;
   logic [7:0] cnt;
   logic [7:0] out_q;
   logic       ready_q;
   logic       busy_q;
   logic       done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         out_q   <= 8'h00;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid && ready_q) begin
                  out_q   <= 8'h01 << bus.in_code;
                  cnt     <= HOLD_LOAD;
                  state   <= HOLD;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            HOLD: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  out_q  <= 8'h00;
                  done_q <= 1'b1;
                  // a zero gap drops straight back to IDLE so done and ready coincide
                  if (GAP_CYCLES > 0) begin
                     cnt   <= GAP_LOAD;
                     state <= GAP;
                  end else begin
                     state   <= IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            GAP: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  state   <= IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= 8'd0;
               out_q   <= 8'h00;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out      = out_q;
   assign bus.in_ready = ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Bench for decoder_3to8_seq: three parameter sets checked every cycle against
// a timeline model (edges since acceptance) plus directed scenario checks.
module tb_decoder_3to8_seq;

   localparam int HP [3] = '{4, 1, 255};
   localparam int GP [3] = '{1, 0, 255};

   logic clk;
   logic rst_n;

   decoder_3to8_seq_if ifa ();
   decoder_3to8_seq_if ifb ();
   decoder_3to8_seq_if ifc ();

   decoder_3to8_seq #(.HOLD_CYCLES(4),   .GAP_CYCLES(1))   u_dut0 (.clk(clk), .rst_n(rst_n), .bus(ifa));
   decoder_3to8_seq #(.HOLD_CYCLES(1),   .GAP_CYCLES(0))   u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifb));
   decoder_3to8_seq #(.HOLD_CYCLES(255), .GAP_CYCLES(255)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc));

   logic       v  [3];
   logic [2:0] c  [3];
   logic [7:0] o  [3];
   logic       rd [3];
   logic       bs [3];
   logic       dn [3];

   assign ifa.in_valid = v[0];
   assign ifa.in_code  = c[0];
   assign ifb.in_valid = v[1];
   assign ifb.in_code  = c[1];
   assign ifc.in_valid = v[2];
   assign ifc.in_code  = c[2];

   assign o[0] = ifa.out;  assign rd[0] = ifa.in_ready;  assign bs[0] = ifa.busy;  assign dn[0] = ifa.done;
   assign o[1] = ifb.out;  assign rd[1] = ifb.in_ready;  assign bs[1] = ifb.busy;  assign dn[1] = ifb.done;
   assign o[2] = ifc.out;  assign rd[2] = ifc.in_ready;  assign bs[2] = ifc.busy;  assign dn[2] = ifc.done;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remembers the edge index of the last acceptance and the code;
   // everything visible is a plain function of edges elapsed since then.
   int         cyc = 0;
   int         e0  [3];
   logic       act [3];
   logic [2:0] mc  [3];
   int         acc [3];
   int         n_done [3];

   function automatic logic model_ready(input int i);
      return !act[i] || ((cyc - e0[i]) >= (HP[i] + GP[i]));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) act[i] <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (model_ready(i) && v[i]) begin
               e0[i]  <= cyc + 1;
               act[i] <= 1'b1;
               mc[i]  <= c[i];
               acc[i] <= acc[i] + 1;
            end
         end
         cyc <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int         k;
         logic [7:0] eo;
         logic       ed, er;
         k  = cyc - e0[i];
         eo = (act[i] && k < HP[i]) ? (8'h01 << mc[i]) : 8'h00;
         ed = act[i] && (k == HP[i]);
         er = !act[i] || (k >= HP[i] + GP[i]);
         chk($sformatf("out%0d", i),   o[i],  eo);
         chk($sformatf("done%0d", i),  dn[i], ed);
         chk($sformatf("ready%0d", i), rd[i], er);
         chk($sformatf("busy%0d", i),  bs[i], !er);
         chk($sformatf("onehot%0d", i), $countones(o[i]) <= 1, 1'b1);
         if (dn[i] === 1'b1) n_done[i]++;
      end
   end

   task automatic send(input int i, input logic [2:0] code, input bit keep);
      int n0, t;
      v[i] = 1'b1;
      c[i] = code;
      n0 = acc[i];
      t = 0;
      while (acc[i] == n0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("accept_timeout", acc[i] != n0, 1'b1);
      if (!keep) v[i] = 1'b0;
   endtask

   initial begin
      int n, d0;
      for (int i = 0; i < 3; i++) begin
         v[i] = 1'b0; c[i] = 3'd0; e0[i] = 0; acc[i] = 0; n_done[i] = 0; mc[i] = 3'd0; act[i] = 1'b0;
      end

      // reset with a pending code
      rst_n = 1'b0;
      v[0] = 1'b1;
      c[0] = 3'd5;
      repeat (3) @(negedge clk);
      chk("rst_out",   o[0],  8'h00);
      chk("rst_ready", rd[0], 1'b1);
      chk("rst_busy",  bs[0], 1'b0);
      chk("rst_done",  dn[0], 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_first_accept", o[0], 8'h20);
      v[0] = 1'b0;
      repeat (8) @(negedge clk);

      // basic decode: 4 hold cycles, done, ready one gap later
      send(0, 3'd3, 0);
      n = 0;
      while (o[0] == 8'h08 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("basic_hold_len", n, 4);
      chk("basic_done",   dn[0], 1'b1);
      chk("basic_gap_rd", rd[0], 1'b0);
      @(negedge clk);
      chk("basic_ready", rd[0], 1'b1);
      chk("basic_nodone", dn[0], 1'b0);

      // sweep with valid held high
      d0 = n_done[0];
      for (int k = 0; k < 8; k++) begin
         send(0, 3'(k), 1);
         chk("sweep_out", o[0], 8'h01 << k);
      end
      v[0] = 1'b0;
      repeat (10) @(negedge clk);
      chk("sweep_done_cnt", n_done[0] - d0, 8);

      // stall: code changes while busy must not disturb the in-flight pulse
      send(0, 3'd2, 1);
      c[0] = 3'd6;
      repeat (2) @(negedge clk);
      chk("stall_inflight", o[0], 8'h04);
      c[0] = 3'd1;
      send(0, 3'd1, 0);
      chk("stall_accept", o[0], 8'h02);
      repeat (8) @(negedge clk);

      // H=1 G=0 corner
      send(1, 3'd7, 0);
      chk("h1_out", o[1], 8'h80);
      @(negedge clk);
      chk("h1_out0",  o[1],  8'h00);
      chk("h1_done",  dn[1], 1'b1);
      chk("h1_ready", rd[1], 1'b1);

      // H=255 G=255 corner
      send(2, 3'd5, 0);
      n = 0;
      while (rd[2] !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("h255_len", n, 510);

      // random traffic on the two short configurations
      for (int r = 0; r < 40; r++) begin
         int i;
         i = int'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(i, 3'($urandom_range(0, 7)), 0);
      end
      repeat (10) @(negedge clk);

      // async reset mid-hold
      send(0, 3'd4, 0);
      @(negedge clk);
      chk("arst_pre", o[0], 8'h10);
      d0 = n_done[0];
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out",   o[0],  8'h00);
      chk("arst_ready", rd[0], 1'b1);
      chk("arst_busy",  bs[0], 1'b0);
      #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("arst_no_done", n_done[0] - d0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/decoder_3to8_seq.md
# decoder_3to8_seq

Sequenced 3-to-8 one-hot decoder: the receive-side counterpart to the team's 8-to-3 encoder. It accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot bit on an 8-bit output. The bit is held for a programmable number of cycles, then followed by a programmable all-zero gap. It sits downstream of encoded selector/event buses and regenerates timed one-hot strobes for line selects, LED or mux enables.

## Interface
- HOLD_CYCLES, default 4: cycles the one-hot output stays asserted per accepted code. Legal range is 1..255.
- GAP_CYCLES, default 1: forced all-zero cycles after each pulse, before the next code is accepted. Legal range is 0..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  3  binary code 0..7 to decode.
- out  output  8  registered one-hot decode (out[in_code]), or all zero.
- busy  output  1  high in HOLD or GAP.
- done  output  1  one-cycle pulse in the cycle immediately after out returns to zero.

## Operation
- All outputs are registered. Reset values: out=8'h00, in_ready=1, busy=0, done=0, state=IDLE, counter=0.
- Reset is asynchronous. Asserting rst_n low mid-pulse or mid-gap clears out to 0 immediately, without waiting for a clock edge. Any in-flight code is discarded.
- Transfer occurs on a rising edge where in_valid && in_ready. in_code is sampled only on that edge.
- The state machine has three states: IDLE, HOLD and GAP.
  - IDLE: in_ready=1, out=0, busy=0. On a transfer, latch the code, set out = 8'h01 << in_code, load counter = HOLD_CYCLES-1, and go to HOLD.
  - HOLD: in_ready=0, busy=1, out holds the one-hot value.
    - If counter != 0, decrement the counter.
    - If counter == 0 and GAP_CYCLES>0: clear out, pulse done, load counter = GAP_CYCLES-1, and go to GAP.
    - If counter == 0 and GAP_CYCLES==0: clear out, pulse done, and go to IDLE.
  - GAP: in_ready=0, busy=1, out=0.
    - If counter != 0, decrement the counter.
    - If counter == 0, go to IDLE.
- Exactly one bit of out is set whenever out != 0. out never holds any other non-zero pattern.
- All 8 codes are legal, so there is no error path.
- in_valid while in_ready=0 has no effect. The source must hold its code until accepted.
- Counter width is 8 bits. The counter never wraps: it is always loaded before a decrement from 0 could occur.
- done is high for exactly one cycle per accepted code. It is never asserted together with a non-zero out.

## Timing
- Let E0 be the transfer edge. One-hot out is visible from E0 until edge E0+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles.
- done is high from edge E0+HOLD_CYCLES to the next edge.
- in_ready returns high after edge E0+HOLD_CYCLES+GAP_CYCLES.
- The earliest next transfer edge is E0+HOLD_CYCLES+GAP_CYCLES+1. Back-to-back period is therefore HOLD_CYCLES+GAP_CYCLES+1 cycles.
- With GAP_CYCLES=0, done and in_ready=1 occur in the same IDLE cycle.
- There is no combinational path from any input to any output. in_ready depends on state only.
- After rst_n deasserts, the first transfer can occur on the first rising edge at which in_valid=1.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 and in_code=5. Require out=00, in_ready=1, busy=0, done=0. Release reset; the next edge accepts the code and out=8'h20.
- Basic decode (H=4, G=1): send code 3. Require out=8'h08 for 4 cycles, then out=0 with done=1 for 1 cycle, then in_ready=1. Total period before the next accept is 6 cycles.
- Sweep: stream codes 0..7 with in_valid held high. Require out to follow 01,02,04,08,10,20,40,80, with exactly 8 done pulses and never two out bits set.
- Stall: assert in_valid with code 6 while busy, changing in_code to 1 mid-HOLD. Require the in-flight pulse unaffected. Code 1 is accepted only on the first in_ready edge, giving out=8'h02.
- Parameter corners: H=1, G=0, code 7. Require out=8'h80 for exactly 1 cycle, then done=1 and in_ready=1 together. H=255 and G=255 must complete without counter wrap.
- Async reset mid-HOLD: pulse rst_n low between edges while out=8'h10. Require out=0 and in_ready=1 before the next edge, and no done pulse afterward.
